instruction_fetch_unit: RTL and testbench

Front end of the MiniAlu core and the reader side of the program ROM. Owns the program counter and drives the ROM address. Captures the combinational 28-bit instruction word into a small prefetch FIFO and presents decoded fields to the execute stage over a valid/ready handshake. Handles taken-branch redirects from execute by flushing and refetching.

---
 rtl/instruction_fetch_unit_pkg.sv | 23 ++
 rtl/instruction_fetch_unit_fetch_fifo.sv | 58 +++++
 rtl/instruction_fetch_unit.sv | 100 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared widths, field positions and fetch states
package instruction_fetch_unit_pkg;

  localparam int IFU_ADDR_WIDTH  = 16;
  localparam int IFU_INSTR_WIDTH = 28;

  localparam int OPCODE_WIDTH = 4;
  localparam int REG_WIDTH    = 8;
  localparam int IMM_WIDTH    = 16;

  localparam int OP_LSB   = 24;
  localparam int DEST_LSB = 16;
  localparam int SRCA_LSB = 8;
  localparam int SRCB_LSB = 0;
  localparam int IMM_LSB  = 0;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_FULL  = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// rtl/instruction_fetch_unit_fetch_fifo.sv - synchronous prefetch fifo with flush
module instruction_fetch_unit_fetch_fifo #(
  parameter int WIDTH = 44,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);

  // Flush drops any push/pop of the same cycle so a redirect starts from a clean buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - program counter, prefetch control and field decode
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = IFU_ADDR_WIDTH,
  parameter int                    INSTR_WIDTH = IFU_INSTR_WIDTH,
  parameter int                    FIFO_DEPTH  = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                    Clock,
  input  logic                    Reset,
  output logic [ADDR_WIDTH-1:0]   oAddress,
  input  logic [INSTR_WIDTH-1:0]  iInstruction,
  input  logic                    iBranchTaken,
  input  logic [ADDR_WIDTH-1:0]   iBranchTarget,
  input  logic                    iReady,
  output logic                    oValid,
  output logic [OPCODE_WIDTH-1:0] oOperation,
  output logic [REG_WIDTH-1:0]    oDestination,
  output logic [REG_WIDTH-1:0]    oSourceA,
  output logic [REG_WIDTH-1:0]    oSourceB,
  output logic [IMM_WIDTH-1:0]    oImmediate,
  output logic [ADDR_WIDTH-1:0]   oInstrPC
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = INSTR_WIDTH + ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0]  pc_q;
  logic [CW-1:0]          count;
  logic [CW-1:0]          count_d;
  logic [EW-1:0]          head_data;
  logic [INSTR_WIDTH-1:0] head_instr;
  logic                   fetch;
  logic                   pop;
  fetch_state_e           state_q;
  fetch_state_e           state_d;

  assign fetch = (state_q != ST_FULL) && !iBranchTaken;
  assign pop   = oValid && iReady && !iBranchTaken;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q <= RESET_PC;
    end else if (iBranchTaken) begin
      pc_q <= iBranchTarget;
    end else if (fetch) begin
      pc_q <= pc_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // State mirrors the fifo occupancy so FULL is known from a register, not from count logic.
  always_comb begin
    count_d = count;
    state_d = ST_FILL;
    case ({fetch, pop})
      2'b10:   count_d = count + CW'(1);
      2'b01:   count_d = count - CW'(1);
      default: count_d = count;
    endcase
    if (iBranchTaken) begin
      state_d = ST_FLUSH;
    end else if (count_d == CW'(FIFO_DEPTH)) begin
      state_d = ST_FULL;
    end
  end

  instruction_fetch_unit_fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk       (Clock),
    .rst       (Reset),
    .push      (fetch),
    .pop       (pop),
    .flush     (iBranchTaken),
    .wr_data   ({iInstruction, pc_q}),
    .head_data (head_data),
    .count     (count)
  );

  assign oAddress     = pc_q;
  assign oValid       = (count != '0);
  assign head_instr   = head_data[ADDR_WIDTH +: INSTR_WIDTH];
  assign oInstrPC     = head_data[ADDR_WIDTH-1:0];
  assign oOperation   = head_instr[OP_LSB +: OPCODE_WIDTH];
  assign oDestination = head_instr[DEST_LSB +: REG_WIDTH];
  assign oSourceA     = head_instr[SRCA_LSB +: REG_WIDTH];
  assign oSourceB     = head_instr[SRCB_LSB +: REG_WIDTH];
  assign oImmediate   = head_instr[IMM_LSB +: IMM_WIDTH];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] oAddress;
  logic [27:0] iInstruction;
  logic        iBranchTaken;
  logic [15:0] iBranchTarget;
  logic        iReady;
  logic        oValid;
  logic [3:0]  oOperation;
  logic [7:0]  oDestination;
  logic [7:0]  oSourceA;
  logic [7:0]  oSourceB;
  logic [15:0] oImmediate;
  logic [15:0] oInstrPC;

  int checks   = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  instruction_fetch_unit dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .oAddress      (oAddress),
    .iInstruction  (iInstruction),
    .iBranchTaken  (iBranchTaken),
    .iBranchTarget (iBranchTarget),
    .iReady        (iReady),
    .oValid        (oValid),
    .oOperation    (oOperation),
    .oDestination  (oDestination),
    .oSourceA      (oSourceA),
    .oSourceB      (oSourceB),
    .oImmediate    (oImmediate),
    .oInstrPC      (oInstrPC)
  );

  function automatic logic [27:0] rom_word(input logic [15:0] a);
    if (a == 16'd0) return 28'h000_0FA9;
    if (a == 16'd1) return 28'h101_007D;
    return {4'hA, a[7:0], a};
  endfunction

  assign iInstruction = rom_word(oAddress);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; iReady = 1'b0; iBranchTaken = 1'b0; iBranchTarget = '0;
    tick(); tick();
    check("rst_valid", oValid, 0);
    check("rst_addr", oAddress, 0);
    check("rst_ipc", oInstrPC, 0);
    check("rst_op", oOperation, 0);

    // first fetch and streaming
    Reset = 1'b0; iReady = 1'b1;
    tick();
    check("t1_valid", oValid, 1);
    check("t1_op", oOperation, 0);
    check("t1_ipc", oInstrPC, 0);
    check("t1_srca", oSourceA, 8'h0F);
    check("t1_srcb", oSourceB, 8'hA9);
    check("t1_addr", oAddress, 1);
    tick();
    check("t2_op", oOperation, 1);
    check("t2_dest", oDestination, 8'h01);
    check("t2_imm", oImmediate, 16'h007D);
    check("t2_ipc", oInstrPC, 1);
    check("t2_addr", oAddress, 2);
    tick();
    check("t3_ipc", oInstrPC, 2);
    check("t3_addr", oAddress, 3);

    // stall from reset: fifo saturates at two entries
    Reset = 1'b1; iReady = 1'b0;
    tick();
    check("r2_valid", oValid, 0);
    check("r2_addr", oAddress, 0);
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("stall_addr", oAddress, 2);
    check("stall_ipc", oInstrPC, 0);
    check("stall_valid", oValid, 1);
    check("stall_srcb", oSourceB, 8'hA9);
    iReady = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("drain_ipc", oInstrPC, i);
      check("drain_valid", oValid, 1);
    end
    // head now PC5, pc=6, count=1
    iReady = 1'b0;
    tick();
    check("b1_ipc", oInstrPC, 5);
    check("b1_addr", oAddress, 7);

    // redirect with fifo holding PCs 5,6; pop must be cancelled
    iBranchTaken = 1'b1; iBranchTarget = 16'h0040; iReady = 1'b1;
    tick();
    iBranchTaken = 1'b0;
    check("b1_flush_valid", oValid, 0);
    check("b1_flush_addr", oAddress, 16'h0040);
    tick();
    check("b1_valid", oValid, 1);
    check("b1_tgt_ipc", oInstrPC, 16'h0040);
    check("b1_tgt_imm", oImmediate, 16'h0040);
    check("b1_tgt_op", oOperation, 4'hA);
    tick();
    check("b1_next_ipc", oInstrPC, 16'h0041);

    // redirect while stalled and full
    iReady = 1'b0;
    tick(); tick();
    check("full_addr", oAddress, 16'h0043);
    tick();
    check("full_hold_addr", oAddress, 16'h0043);
    check("full_hold_ipc", oInstrPC, 16'h0041);
    iBranchTaken = 1'b1; iBranchTarget = 16'h0003;
    tick();
    iBranchTaken = 1'b0;
    check("b2_flush_valid", oValid, 0);
    check("b2_flush_addr", oAddress, 16'h0003);
    tick();
    check("b2_valid", oValid, 1);
    check("b2_ipc", oInstrPC, 16'h0003);

    // pc wrap
    iReady = 1'b1; iBranchTaken = 1'b1; iBranchTarget = 16'hFFFF;
    tick();
    iBranchTaken = 1'b0;
    check("wrap_addr0", oAddress, 16'hFFFF);
    tick();
    check("wrap_ipc0", oInstrPC, 16'hFFFF);
    check("wrap_dest", oDestination, 8'hFF);
    check("wrap_addr1", oAddress, 16'h0000);
    tick();
    check("wrap_ipc1", oInstrPC, 16'h0000);
    check("wrap_addr2", oAddress, 16'h0001);

    // reset mid-stream with two buffered words
    iReady = 1'b0;
    tick();
    check("pre_rst_addr", oAddress, 16'h0002);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("mid_rst_valid", oValid, 0);
    check("mid_rst_addr", oAddress, 0);
    check("mid_rst_ipc", oInstrPC, 0);
    tick();
    check("post_rst_valid", oValid, 1);
    check("post_rst_ipc", oInstrPC, 0);
    check("post_rst_srca", oSourceA, 8'h0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
